// File: rtl/random_generator_pkg.sv
// Shared constants for the tic-tac-toe random move picker: board size, the
// "no free cell" code, the LFSR seed and the feedback tap positions.
package random_generator_pkg;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] NO_CELL   = 4'hF;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (maximal length, period 255)
  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  function automatic logic [3:0] mod9(input logic [7:0] v);
    logic [7:0] r;
    r = v % 8'd9;
    return r[3:0];
  endfunction

endpackage

// File: rtl/random_generator_lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left with feedback into bit 0 every clock.
// Never reaches zero because the seed is non-zero and the polynomial is maximal.
module lfsr8
  import random_generator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D]};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/random_generator.sv
// Picks a pseudo-random free board cell: scan starts at lfsr mod 9 and wraps,
// result registered with one cycle of latency; 4'hF when the board is full.
module random_generator
  import random_generator_pkg::*;
(
  input  logic [8:0] Xcells,
  input  logic [8:0] Ocells,
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] random
);

  logic [7:0] lfsr;
  logic [8:0] free;
  logic [3:0] start;
  logic [3:0] random_q;
  logic [3:0] random_d;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  // A cell marked by both players still counts as occupied.
  assign free  = ~(Xcells | Ocells);
  assign start = mod9(lfsr);

  always_comb begin
    logic [4:0] idx;
    logic       found;
    random_d = NO_CELL;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      idx = {1'b0, start} + 5'(k);
      if (idx >= 5'(NUM_CELLS)) begin
        idx = idx - 5'(NUM_CELLS);
      end
      if (!found && free[idx[3:0]]) begin
        random_d = idx[3:0];
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      random_q <= NO_CELL;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;

endmodule

// File: tb/tb_random_generator.sv
// Directed bench for random_generator: hand-computed vector table plus
// multi-cycle sequences for full board, single free cell, period and mid-run reset.
module tb_random_generator;

  logic [8:0] Xcells;
  logic [8:0] Ocells;
  logic       clk;
  logic       reset;
  logic [3:0] random;

  int passed = 0;
  int total  = 0;

  random_generator dut (
    .Xcells (Xcells),
    .Ocells (Ocells),
    .clk    (clk),
    .reset  (reset),
    .random (random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] x;
    logic [8:0] o;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge_sample();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial begin
    logic [3:0]  held;
    logic [7:0]  m;
    logic [8:0]  seen;
    int          over8;
    logic [3:0]  first_vals[3];

    // LFSR states after reset: A5,4A,95,2A,54,A9,53,A7 -> starts 3,2,5,6,3,7,2,5
    vecs[0] = '{9'b000_000_000, 9'b000_000_000, 4'd3};
    vecs[1] = '{9'b000_000_100, 9'b000_000_000, 4'd3};
    vecs[2] = '{9'b000_000_000, 9'b001_100_000, 4'd7};
    vecs[3] = '{9'b011_000_000, 9'b100_000_000, 4'd0};
    vecs[4] = '{9'b111_111_101, 9'b000_000_000, 4'd1};
    vecs[5] = '{9'b110_000_000, 9'b110_000_000, 4'd0};
    vecs[6] = '{9'b101_010_101, 9'b010_101_010, 4'hF};
    vecs[7] = '{9'b111_101_111, 9'b000_000_000, 4'd4};

    Xcells = '0;
    Ocells = '0;
    reset  = 1'b0;

    // Reset state, checked before any further edge
    do_reset();
    check("reset_value", random, 4'hF);

    for (int i = 0; i < 8; i++) begin
      Xcells = vecs[i].x;
      Ocells = vecs[i].o;
      edge_sample();
      check($sformatf("vec%0d", i), random, vecs[i].exp);
    end

    // Output holds between edges when inputs change
    held   = random;
    Xcells = 9'b111_111_111;
    #2;
    check("hold_between_edges", random, held);

    // Full board (overlap on cell 0) -> F every cycle
    Xcells = 9'b111_111_110;
    Ocells = 9'b000_000_001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      edge_sample();
      check($sformatf("full_board_c%0d", i), random, 4'hF);
    end

    // Empty board: 3 then 2 right after reset
    Xcells = '0;
    Ocells = '0;
    do_reset();
    edge_sample();
    check("empty_edge1", random, 4'd3);
    edge_sample();
    check("empty_edge2", random, 4'd2);

    // Only cell 4 free for 300 cycles
    Xcells = 9'b111_101_111;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      edge_sample();
      check($sformatf("only_cell4_c%0d", i), random, 4'd4);
    end

    // Empty board over a full LFSR period, predicted from the polynomial
    Xcells = '0;
    Ocells = '0;
    do_reset();
    m     = 8'hA5;
    seen  = '0;
    over8 = 0;
    for (int i = 0; i < 255; i++) begin
      edge_sample();
      check($sformatf("period_c%0d", i), random, 4'(m % 8'd9));
      if (random <= 4'd8) seen[random] = 1'b1;
      else over8++;
      m = lfsr_step(m);
    end
    check("all_cells_seen", {3'b0, &seen}, 4'd1);
    check("none_above_8", 4'(over8), 4'd0);
    // After 255 advances the LFSR is back at A5: sequence repeats 3, 2
    edge_sample();
    check("period_wrap1", random, 4'd3);
    edge_sample();
    check("period_wrap2", random, 4'd2);

    // Mid-run reset restarts the identical sequence
    first_vals[0] = 4'd3;
    first_vals[1] = 4'd2;
    first_vals[2] = 4'd5;
    for (int i = 0; i < 7; i++) edge_sample();
    do_reset();
    check("midrun_reset", random, 4'hF);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check($sformatf("midrun_seq%0d", i), random, first_vals[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/random_generator.md
RANDOM_GENERATOR -- requirements
Module: random_generator

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have the port Xcells, input, 9 bits: bit i set means board cell i is occupied by X; cells are 0..8.
REQ-005 The block SHALL have the port Ocells, input, 9 bits: bit i set means board cell i is occupied by O.
REQ-006 The block SHALL have the port random, output, 4 bits, registered: the selected free cell index 0..8, or 4'hF when no cell is free.
REQ-007 The positional port order SHALL be Xcells, Ocells, clk, reset, random.
REQ-008 The block SHALL have no parameters.

Function
REQ-009 The free mask SHALL be free[i] = ~(Xcells[i] | Ocells[i]); a cell with both bits set SHALL count as occupied.
REQ-010 An internal 8-bit Fibonacci LFSR SHALL advance once per clock when reset is low: lfsr_next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; its period SHALL be 255, and it SHALL never reach 0.
REQ-011 The start index SHALL be start = lfsr mod 9, with a range of 0..8, computed from the current, pre-update LFSR value.
REQ-012 The selected cell SHALL be the first i with free[i] = 1, scanning start, start+1, ... with 8 wrapping to 0, covering all 9 cells.
REQ-013 If free = 0, the selection SHALL be 4'hF.
REQ-014 On every rising clock edge with reset low, random SHALL load the selection, which is a combinational function of the current LFSR value and the current inputs, giving 1-cycle latency.
REQ-015 Input changes SHALL affect random only at the next clock edge; random SHALL hold its value between edges.
REQ-016 random SHALL never take any value 9..14.
REQ-017 The LFSR SHALL advance regardless of the board contents, including a full board.

Reset
REQ-018 With reset high at a rising edge, lfsr SHALL load 8'hA5 and random SHALL load 4'hF.
REQ-019 Reset SHALL take priority over all other activity; asserting reset mid-operation SHALL restart the identical sequence from the seed.

Structure
REQ-020 A shared package SHALL hold the constants NUM_CELLS = 9, NO_CELL = 4'hF, LFSR_SEED = 8'hA5, and the tap positions.
REQ-021 A single sub-module, lfsr8 (ports clk, reset, q[7:0]), SHALL implement the LFSR; the mod-9 and wrap-scan logic SHALL stay in random_generator.

Verification
REQ-022 Reset pulse followed by a check before any further edge -> random = 4'hF.
REQ-023 Xcells = 9'b111_111_110, Ocells = 9'b000_000_001, 10 clocks after reset -> random = 4'hF on every cycle.
REQ-024 Empty board, reset then clocks -> random = 3 after the 1st edge (lfsr A5 gives 165 mod 9) and 2 after the 2nd edge (lfsr 4A gives 74 mod 9).
REQ-025 Only cell 4 free (Xcells = 9'b111_101_111, Ocells = 0) -> random = 4 on every edge for 300 cycles.
REQ-026 Empty board for 255 cycles -> every value in 0..8 appears, no value is above 8, and the LFSR returns to A5 after 255 advances.
REQ-027 Reset asserted mid-run with an empty board -> random = F, then 3, 2, ... as in REQ-024.
